// File: rtl/led_rate_gen.sv
// Programmable square-wave generator for the LED ping-pong scanner: a 50% duty
// led_clk with a one-cycle led_tick on each rising edge, speed adjustable at run time.
module led_rate_gen #(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 25000000,
    parameter int MIN_DIV     = 1000000,
    parameter int MAX_DIV     = 50000000,
    parameter int STEP_DIV    = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             speed_up,
    input  logic             speed_down,
    input  logic             speed_reset,
    input  logic             pause,
    output logic             led_clk,
    output logic             led_tick,
    output logic [CNT_W-1:0] div_value
);

    localparam logic [CNT_W-1:0] DEF_N  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W:0]   MIN_W  = (CNT_W+1)'(MIN_DIV);
    localparam logic [CNT_W:0]   MAX_W  = (CNT_W+1)'(MAX_DIV);
    localparam logic [CNT_W:0]   STEP_W = (CNT_W+1)'(STEP_DIV);

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W:0]   div_wide;
    logic [CNT_W:0]   sum_wide;
    logic             terminal;

    assign div_wide = {1'b0, div_value};
    assign sum_wide = div_wide + STEP_W;

    // Greater-or-equal so a divisor shrunk below the live count fires at once.
    assign terminal = (counter >= (div_value - CNT_W'(1)));

    // Divisor saturation checks bounds before the subtract so it never wraps.
    always_comb begin
        div_next = div_value;
        if (speed_reset) begin
            div_next = DEF_N;
        end else if (speed_up && !speed_down) begin
            if (div_wide >= (MIN_W + STEP_W)) begin
                div_next = div_value - STEP_W[CNT_W-1:0];
            end else begin
                div_next = MIN_W[CNT_W-1:0];
            end
        end else if (speed_down && !speed_up) begin
            if (sum_wide > MAX_W) begin
                div_next = MAX_W[CNT_W-1:0];
            end else begin
                div_next = sum_wide[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_value <= DEF_N;
        end else begin
            div_value <= div_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter  <= '0;
            led_clk  <= 1'b0;
            led_tick <= 1'b0;
        end else if (pause) begin
            led_tick <= 1'b0;
        end else if (terminal) begin
            counter  <= '0;
            led_clk  <= ~led_clk;
            led_tick <= ~led_clk;
        end else begin
            counter  <= counter + CNT_W'(1);
            led_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_rate_gen.sv
// Self-checking bench for led_rate_gen: scoreboard of spec-level expectations
// plus a command table and hand-written multi-cycle corner sequences.
module tb_led_rate_gen;

    localparam int CNT_W = 8;
    localparam int DEF   = 4;
    localparam int MIN   = 2;
    localparam int MAX   = 8;
    localparam int STEP  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             speed_up = 1'b0;
    logic             speed_down = 1'b0;
    logic             speed_reset = 1'b0;
    logic             pause = 1'b0;
    logic             led_clk;
    logic             led_tick;
    logic [CNT_W-1:0] div_value;

    led_rate_gen #(
        .CNT_W(CNT_W), .DEFAULT_DIV(DEF), .MIN_DIV(MIN), .MAX_DIV(MAX), .STEP_DIV(STEP)
    ) dut (
        .clk(clk), .reset(reset), .speed_up(speed_up), .speed_down(speed_down),
        .speed_reset(speed_reset), .pause(pause), .led_clk(led_clk),
        .led_tick(led_tick), .div_value(div_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit clk_v;
        bit tick_v;
        int div_v;
    } exp_t;

    typedef struct {
        bit su;
        bit sd;
        bit sr;
        bit pz;
        int exp_div;
        int period;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state, written from the behavioural description.
    int m_cnt = 0;
    bit m_clk = 0;
    int m_div = DEF;

    task automatic checkValue(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_cnt = 0;
        m_clk = 0;
        m_div = DEF;
        sb_q.delete();
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = sb_q.pop_front();
        checkValue("sb_led_clk", int'(led_clk), int'(e.clk_v));
        checkValue("sb_led_tick", int'(led_tick), int'(e.tick_v));
        checkValue("sb_div_value", int'(div_value), e.div_v);
    endtask

    task automatic applyStimulus(input bit su, input bit sd, input bit sr, input bit pz);
        exp_t e;
        int   old_div;
        speed_up    = su;
        speed_down  = sd;
        speed_reset = sr;
        pause       = pz;
        old_div = m_div;
        e.tick_v = 0;
        if (!pz) begin
            if (m_cnt >= old_div - 1) begin
                m_cnt = 0;
                m_clk = ~m_clk;
                e.tick_v = m_clk;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (sr) m_div = DEF;
        else if (su && sd) m_div = m_div;
        else if (su) m_div = (m_div - STEP < MIN) ? MIN : m_div - STEP;
        else if (sd) m_div = (m_div + STEP > MAX) ? MAX : m_div + STEP;
        e.clk_v = m_clk;
        e.div_v = m_div;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit su, input bit sd, input bit sr, input bit pz);
        applyStimulus(su, sd, sr, pz);
        checkOutput();
    endtask

    task automatic waitTick(input string name);
        bit found = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            step(0, 0, 0, 0);
            if (led_tick) found = 1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: got no led_tick, expected one within 64 cycles", name);
        end
    endtask

    task automatic measurePeriod(input int expected);
        int gap = 0;
        bit found = 0;
        waitTick("period_sync");
        for (int k = 1; k <= 40 && !found; k++) begin
            step(0, 0, 0, 0);
            if (led_tick) begin
                gap = k;
                found = 1;
            end
        end
        checkValue("tick_period", gap, expected);
    endtask

    vec_t table_v[$];

    initial begin
        table_v.push_back('{su:1, sd:0, sr:0, pz:0, exp_div:2, period:0});
        table_v.push_back('{su:1, sd:0, sr:0, pz:0, exp_div:2, period:0});
        table_v.push_back('{su:1, sd:0, sr:0, pz:0, exp_div:2, period:4});
        table_v.push_back('{su:0, sd:0, sr:1, pz:0, exp_div:4, period:0});
        table_v.push_back('{su:0, sd:1, sr:0, pz:0, exp_div:6, period:0});
        table_v.push_back('{su:0, sd:1, sr:0, pz:0, exp_div:8, period:0});
        table_v.push_back('{su:0, sd:1, sr:0, pz:0, exp_div:8, period:16});
        table_v.push_back('{su:1, sd:1, sr:0, pz:0, exp_div:8, period:0});
        table_v.push_back('{su:0, sd:1, sr:1, pz:0, exp_div:4, period:8});

        // Reset values while reset is held.
        #12;
        checkValue("reset_led_clk", int'(led_clk), 0);
        checkValue("reset_led_tick", int'(led_tick), 0);
        checkValue("reset_div_value", int'(div_value), DEF);
        @(negedge clk);
        reset = 1'b0;
        modelReset();

        // Free run: rise on edge 4, fall on edge 8, tick on 4, 12, 20, ...
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 0);
            checkValue("free_led_tick", int'(led_tick), (i % 8 == 4) ? 1 : 0);
            checkValue("free_led_clk", int'(led_clk), ((i % 8) >= 4) ? 1 : 0);
        end

        // Table of speed commands with hand-derived divisor results.
        foreach (table_v[i]) begin
            step(table_v[i].su, table_v[i].sd, table_v[i].sr, table_v[i].pz);
            checkValue("table_div_value", int'(div_value), table_v[i].exp_div);
            step(0, 0, 0, 0);
            if (table_v[i].period != 0) measurePeriod(table_v[i].period);
        end

        // Divisor 8, counter at 3..5 while shrinking to 4: toggle on the very next edge.
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        checkValue("corner_div8", int'(div_value), 8);
        step(0, 0, 0, 0);
        waitTick("corner_sync");
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checkValue("corner_div4", int'(div_value), 4);
        checkValue("corner_pre_clk", int'(led_clk), 1);
        step(0, 0, 0, 0);
        checkValue("corner_early_fall", int'(led_clk), 0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0);
            checkValue("corner_low_hold", int'(led_clk), 0);
        end
        step(0, 0, 0, 0);
        checkValue("corner_rise_clk", int'(led_clk), 1);
        checkValue("corner_rise_tick", int'(led_tick), 1);

        // Pause mid half-period with a speed_down accepted while frozen.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, k == 3, 0, 1);
            checkValue("pause_led_clk", int'(led_clk), 1);
            checkValue("pause_led_tick", int'(led_tick), 0);
        end
        checkValue("pause_div_value", int'(div_value), 6);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0);
            checkValue("resume_hold", int'(led_clk), 1);
        end
        step(0, 0, 0, 0);
        checkValue("resume_fall", int'(led_clk), 0);

        // Asynchronous reset between clock edges, right after a rising toggle.
        waitTick("reset_sync");
        #2;
        reset = 1'b1;
        #1;
        checkValue("async_led_clk", int'(led_clk), 0);
        checkValue("async_led_tick", int'(led_tick), 0);
        checkValue("async_div_value", int'(div_value), DEF);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0);
            checkValue("post_reset_tick", int'(led_tick), (i == 4) ? 1 : 0);
        end

        checkValue("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected end before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
